// File: rtl/debounce_pkg.sv
// Shared types and width helper for the mechanical-input debouncer.
package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        PEND_HI   = 2'd1,
        STABLE_HI = 2'd2,
        PEND_LO   = 2'd3
    } debounce_state_t;

    // Counter width for a range of n values, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = int'($clog2(n));
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/debouncer.sv
// Debounces one synchronized input level into a clean level plus rise/fall pulses.
// Optional long-press detection is built when DEBOUNCER_LONG_PRESS_EN is defined.
module debouncer
    import debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned HOLD_CYCLES     = 50_000_000,
    parameter bit          INIT_LEVEL      = 1'b0
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic data_in,
    output logic clean_out,
    output logic rise_out,
    output logic fall_out,
    output logic busy_out,
    output logic hold_out
);

    localparam int unsigned          CNT_W       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]     CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam debounce_state_t      RESET_STATE = INIT_LEVEL ? STABLE_HI : STABLE_LO;

    if (DEBOUNCE_CYCLES < 2 || HOLD_CYCLES < 1) begin : g_bad_cfg
        $error("debouncer: DEBOUNCE_CYCLES must be >= 2 and HOLD_CYCLES >= 1");
    end

    debounce_state_t  state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             clean_next, rise_next, fall_next, busy_next;

    // State, counter and registered outputs.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state     <= RESET_STATE;
            cnt       <= '0;
            clean_out <= INIT_LEVEL;
            rise_out  <= 1'b0;
            fall_out  <= 1'b0;
            busy_out  <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            clean_out <= clean_next;
            rise_out  <= rise_next;
            fall_out  <= fall_next;
            busy_out  <= busy_next;
        end
    end

    // Every sample of the window must agree; any disagreement drops back to stable.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        clean_next = clean_out;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        case (state)
            STABLE_LO: begin
                if (data_in) begin
                    state_next = PEND_HI;
                    cnt_next   = CNT_W'(1);
                end
            end
            PEND_HI: begin
                if (!data_in) begin
                    state_next = STABLE_LO;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = STABLE_HI;
                    clean_next = 1'b1;
                    rise_next  = 1'b1;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            STABLE_HI: begin
                if (!data_in) begin
                    state_next = PEND_LO;
                    cnt_next   = CNT_W'(1);
                end
            end
            PEND_LO: begin
                if (data_in) begin
                    state_next = STABLE_HI;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = STABLE_LO;
                    clean_next = 1'b0;
                    fall_next  = 1'b1;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = RESET_STATE;
                cnt_next   = '0;
            end
        endcase
        busy_next = (state_next == PEND_HI) || (state_next == PEND_LO);
    end

`ifdef DEBOUNCER_LONG_PRESS_EN
    localparam int unsigned       HOLD_W   = cnt_width(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);

    logic [HOLD_W-1:0] hold_cnt, hold_cnt_next;
    logic              hold_next;

    // Counts while the accepted level is high; bounces in PEND_LO keep counting.
    always_comb begin
        hold_cnt_next = hold_cnt;
        hold_next     = 1'b0;
        if (rise_next || fall_next) begin
            hold_cnt_next = '0;
        end else if ((state == STABLE_HI || state == PEND_LO) && hold_cnt != HOLD_MAX) begin
            hold_cnt_next = hold_cnt + HOLD_W'(1);
            hold_next     = (hold_cnt_next == HOLD_MAX);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            hold_cnt <= '0;
            hold_out <= 1'b0;
        end else begin
            hold_cnt <= hold_cnt_next;
            hold_out <= hold_next;
        end
    end
`else
    assign hold_out = 1'b0;
`endif

endmodule

// File: tb/tb_debouncer.sv
// Directed and seeded-random checks of debouncer with DEBOUNCE_CYCLES=4, HOLD_CYCLES=8.
module tb_debouncer;

    logic clk;
    logic rst_n;
    logic data_in;
    logic clean_out, rise_out, fall_out, busy_out, hold_out;

    int total = 0;
    int bad   = 0;

    debouncer #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (8),
        .INIT_LEVEL     (1'b0)
    ) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .data_in  (data_in),
        .clean_out(clean_out),
        .rise_out (rise_out),
        .fall_out (fall_out),
        .busy_out (busy_out),
        .hold_out (hold_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "tb_debouncer timed out");
    end

    task automatic check(input string tag, input logic got, input logic exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        data_in = 1'b0;
        rst_n   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Bit i of each vector is the input for, or expected output after, edge i.
    task automatic run_vec(input string name, input int n, input logic [31:0] d,
                           input logic [31:0] c, input logic [31:0] r,
                           input logic [31:0] f, input logic [31:0] b);
        string t;
        for (int i = 0; i < n; i++) begin
            data_in = d[i];
            @(posedge clk);
            #1;
            t = $sformatf("%s[%0d]", name, i);
            check({t, ".clean"}, clean_out, c[i]);
            check({t, ".rise"},  rise_out,  r[i]);
            check({t, ".fall"},  fall_out,  f[i]);
            check({t, ".busy"},  busy_out,  b[i]);
`ifndef DEBOUNCER_LONG_PRESS_EN
            check({t, ".hold"},  hold_out,  1'b0);
`endif
        end
    endtask

    // Mid-cycle reset must clear outputs without a clock edge.
    task automatic async_reset_check(input string name);
        #2;
        rst_n = 1'b0;
        #1;
        check({name, ".clean"}, clean_out, 1'b0);
        check({name, ".busy"},  busy_out,  1'b0);
        check({name, ".rise"},  rise_out,  1'b0);
        check({name, ".fall"},  fall_out,  1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic d, prev, exp_r, exp_f, exp_h;
        int   m_run, m_h;
        logic m_clean;

        data_in = 1'b0;
        rst_n   = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("reset.clean", clean_out, 1'b0);
        check("reset.rise",  rise_out,  1'b0);
        check("reset.fall",  fall_out,  1'b0);
        check("reset.busy",  busy_out,  1'b0);
        check("reset.hold",  hold_out,  1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_vec("press",       10, 32'h3FF, 32'h3F8, 32'h008, 32'h000, 32'h007);
        run_vec("release",      6, 32'h000, 32'h007, 32'h000, 32'h008, 32'h007);
        run_vec("short_hi",     6, 32'h007, 32'h000, 32'h000, 32'h000, 32'h007);
        run_vec("bounce_hi",   10, 32'h3ED, 32'h300, 32'h100, 32'h000, 32'h0ED);
        run_vec("late_glitch",  5, 32'h018, 32'h01F, 32'h000, 32'h000, 32'h007);
        run_vec("toggle",       8, 32'h0AA, 32'h0FF, 32'h000, 32'h000, 32'h055);

        run_vec("pend_lo",      2, 32'h000, 32'h003, 32'h000, 32'h000, 32'h003);
        async_reset_check("rst_pend_lo");
        run_vec("repress",     10, 32'h3FF, 32'h3F8, 32'h008, 32'h000, 32'h007);
        run_vec("rerelease",    6, 32'h000, 32'h007, 32'h000, 32'h008, 32'h007);
        run_vec("pend_hi",      2, 32'h003, 32'h000, 32'h000, 32'h000, 32'h003);
        async_reset_check("rst_pend_hi");
        run_vec("after_rst",   10, 32'h3FF, 32'h3F8, 32'h008, 32'h000, 32'h007);

        // Random bounce run against a run-length reference model.
        do_reset();
        d = 1'b0;
        m_clean = 1'b0;
        m_run = 0;
        m_h = 0;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(5) == 0) begin
                d = ~d;
            end
            data_in = d;
            @(posedge clk);
            #1;
            prev  = m_clean;
            exp_r = 1'b0;
            exp_f = 1'b0;
            exp_h = 1'b0;
            if (d != m_clean) begin
                m_run++;
                if (m_run == 4) begin
                    m_clean = d;
                    m_run   = 0;
                    exp_r   = d;
                    exp_f   = ~d;
                end
            end else begin
                m_run = 0;
            end
            if (exp_r || exp_f) begin
                m_h = 0;
            end else if (prev && m_h != 8) begin
                m_h++;
                exp_h = (m_h == 8);
            end
`ifndef DEBOUNCER_LONG_PRESS_EN
            exp_h = 1'b0;
`endif
            check("rand.clean",      clean_out,            m_clean);
            check("rand.rise",       rise_out,             exp_r);
            check("rand.fall",       fall_out,             exp_f);
            check("rand.busy",       busy_out,             logic'(m_run != 0));
            check("rand.no_overlap", rise_out & fall_out,  1'b0);
            check("rand.hold",       hold_out,             exp_h);
        end

`ifdef DEBOUNCER_LONG_PRESS_EN
        // Long press with a one-cycle bounce at edge 8; hold fires once, 8 cycles after rise.
        do_reset();
        for (int i = 0; i < 22; i++) begin
            data_in = (i == 8) ? 1'b0 : 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("long[%0d].rise", i), rise_out, logic'(i == 3));
            check($sformatf("long[%0d].hold", i), hold_out, logic'(i == 11));
        end
        // Short press: released before the hold window completes.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            data_in = (i < 5) ? 1'b1 : 1'b0;
            @(posedge clk);
            #1;
            check($sformatf("short[%0d].fall", i), fall_out, logic'(i == 8));
            check($sformatf("short[%0d].hold", i), hold_out, 1'b0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
